extfreq_ctr: RTL and testbench

- Parametrised successor of the external-frequency block, in the local clock domain (the DCM-multiplied clock, 125 MHz nominal).
- Synchronises the external reference, measures its period in local clocks and runs a lock/loss monitor.
- Provides a free-running timestamp counter with reset/inhibit and an optional mode that aligns counter reset to a reference edge.
- Feeds trigger timestamping and the lock-status register.

---
 rtl/extfreq_ctr.sv | 168 ++++++++++++++++
 tb/tb_extfreq_ctr.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/extfreq_ctr.sv
// External-reference monitor in the local clock domain: period measurement, lock/loss tracking,
// and a timestamp counter whose reset can optionally be aligned to a reference edge.
`timescale 1ns/1ps
module extfreq_ctr #(
    parameter int CNT_WIDTH = 22,
    parameter int MULT      = 8,
    parameter int TOL       = 1,
    parameter int LOCK_CNT  = 4,
    parameter int PW        = 6,
    parameter bit ALIGN     = 1'b0
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 freqin,
    input  logic                 cnt_reset,
    input  logic                 cnt_inhibit,
    input  logic                 clear_lost,
    output logic [CNT_WIDTH-1:0] counter,
    output logic                 locked,
    output logic                 lost,
    output logic [PW-1:0]        period,
    output logic                 align_pending
);
    localparam logic [PW-1:0]        PMAX   = '1;
    localparam logic [PW-1:0]        TMO    = PW'(2 * MULT);
    localparam int                   GW     = $clog2(LOCK_CNT + 1);
    localparam logic signed [PW+1:0] MULT_S = (PW+2)'(MULT);
    localparam logic signed [PW+1:0] TOL_S  = (PW+2)'(TOL);

    typedef enum logic [1:0] {UNLOCKED, ACQUIRE, LOCKED_ST} state_t;

    function automatic logic [PW-1:0] sat_inc(input logic [PW-1:0] v);
        return (v == PMAX) ? PMAX : v + PW'(1);
    endfunction

    function automatic logic within_tol(input logic [PW-1:0] p);
        logic signed [PW+1:0] dev;
        dev = $signed({2'b00, p}) - MULT_S;
        if (dev < 0) dev = -dev;
        return dev <= TOL_S;
    endfunction

    logic          sync_p0, sync_p1, hist_p2;
    logic          ref_edge, good, timeout, loss;
    logic [PW-1:0] pcnt, period_new;
    logic [GW-1:0] gcnt, gcnt_nxt;
    state_t        state, state_nxt;
    logic          res_p0, res_p1, inh_p0;
    logic          align_fire, clr;

    // Stage boundary: two synchroniser flops plus one history flop for edge detection
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
            hist_p2 <= 1'b0;
        end else begin
            sync_p0 <= freqin;
            sync_p1 <= sync_p0;
            hist_p2 <= sync_p1;
        end
    end

    assign ref_edge   = sync_p1 & ~hist_p2;
    assign period_new = sat_inc(pcnt);
    assign good       = within_tol(period_new);
    // pcnt only passes through 2*MULT once per interval, so this is naturally a single pulse
    assign timeout    = ~ref_edge & (pcnt == TMO);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pcnt   <= '0;
            period <= '0;
        end else if (ref_edge) begin
            pcnt   <= '0;
            period <= period_new;
        end else begin
            pcnt   <= sat_inc(pcnt);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= UNLOCKED;
            gcnt  <= '0;
        end else begin
            state <= state_nxt;
            gcnt  <= gcnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            UNLOCKED:  if (ref_edge) state_nxt = ACQUIRE;
            ACQUIRE: begin
                if (timeout)
                    state_nxt = UNLOCKED;
                else if (ref_edge && good && gcnt == GW'(LOCK_CNT - 1))
                    state_nxt = LOCKED_ST;
            end
            LOCKED_ST: if (timeout || (ref_edge && !good)) state_nxt = UNLOCKED;
            default:   state_nxt = UNLOCKED;
        endcase
    end

    always_comb begin
        gcnt_nxt = gcnt;
        loss     = 1'b0;
        case (state)
            UNLOCKED: if (ref_edge) gcnt_nxt = '0;
            ACQUIRE: begin
                if (ref_edge) begin
                    if (!good)
                        gcnt_nxt = '0;
                    else if (gcnt == GW'(LOCK_CNT - 1))
                        gcnt_nxt = '0;
                    else
                        gcnt_nxt = gcnt + GW'(1);
                end
            end
            LOCKED_ST: begin
                gcnt_nxt = '0;
                loss     = timeout | (ref_edge & ~good);
            end
            default: gcnt_nxt = '0;
        endcase
    end

    // A loss event outranks a simultaneous clear so no loss is ever missed
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            locked <= 1'b0;
            lost   <= 1'b0;
        end else begin
            locked <= (state == LOCKED_ST);
            if (loss)
                lost <= 1'b1;
            else if (clear_lost)
                lost <= 1'b0;
        end
    end

    assign align_fire = ALIGN & align_pending & ref_edge;
    assign clr        = ALIGN ? align_fire : res_p0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            res_p0        <= 1'b0;
            res_p1        <= 1'b0;
            inh_p0        <= 1'b0;
            align_pending <= 1'b0;
            counter       <= '0;
        end else begin
            res_p0 <= cnt_reset;
            res_p1 <= res_p0;
            inh_p0 <= cnt_inhibit;
            if (align_fire)
                align_pending <= 1'b0;
            else if (ALIGN && res_p0 && !res_p1)
                align_pending <= 1'b1;
            if (clr)
                counter <= '0;
            else if (!inh_p0)
                counter <= counter + CNT_WIDTH'(1);
        end
    end
endmodule

// File: tb/tb_extfreq_ctr.sv
// Bench for extfreq_ctr: a default instance and an ALIGN=1 narrow-counter instance share stimulus;
// a per-cycle reference model feeds a scoreboard, plus directed checks at the key events.
`timescale 1ns/1ps
module tb_extfreq_ctr;
    localparam int MULT = 8, TOL = 1, LOCK_CNT = 4, PMAX = 63;

    logic        clk = 1'b0, reset_n = 1'b1;
    logic        freqin = 1'b0, cnt_reset = 1'b0, cnt_inhibit = 1'b0, clear_lost = 1'b0;
    logic [21:0] counter_a;
    logic [7:0]  counter_b;
    logic        locked_a, lost_a, align_pending_a, locked_b, lost_b, align_pending_b;
    logic [5:0]  period_a, period_b;
    int          vectors = 0, miscompares = 0, cyc = 0;

    extfreq_ctr dut_a (.clk(clk), .reset_n(reset_n), .freqin(freqin), .cnt_reset(cnt_reset),
        .cnt_inhibit(cnt_inhibit), .clear_lost(clear_lost), .counter(counter_a), .locked(locked_a),
        .lost(lost_a), .period(period_a), .align_pending(align_pending_a));
    extfreq_ctr #(.CNT_WIDTH(8), .ALIGN(1'b1)) dut_b (.clk(clk), .reset_n(reset_n), .freqin(freqin),
        .cnt_reset(cnt_reset), .cnt_inhibit(cnt_inhibit), .clear_lost(clear_lost), .counter(counter_b),
        .locked(locked_b), .lost(lost_b), .period(period_b), .align_pending(align_pending_b));

    always #5 clk = ~clk;

    typedef struct packed {
        bit s1, s2, h;
        int pcnt, period, st, run;
        bit locked, lost, res, resq, inh, pend;
        longint cnt;
    } mdl_t;

    typedef struct packed {
        logic [31:0] cnt;
        logic        locked;
        logic        lost;
        logic [7:0]  period;
        logic        pend;
    } exp_t;

    mdl_t ma = '0, mb = '0;
    exp_t qa[$], qb[$];

    // st: 0 unlocked, 1 acquiring, 2 locked; run counts consecutive good periods
    function automatic mdl_t mstep(mdl_t m, bit fin, bit creset, bit cinh, bit clr, bit align, int cw);
        mdl_t n = m;
        bit   e = m.s2 && !m.h;
        int   meas = (m.pcnt >= PMAX) ? PMAX : m.pcnt + 1;
        bit   ok = (meas >= MULT - TOL) && (meas <= MULT + TOL);
        bit   tmo = !e && (m.pcnt == 2 * MULT);
        bit   drop = 1'b0;
        bit   fire = align && m.pend && e;
        n.s1 = fin; n.s2 = m.s1; n.h = m.s2;
        n.pcnt = e ? 0 : ((m.pcnt < PMAX) ? m.pcnt + 1 : PMAX);
        if (e) n.period = meas;
        case (m.st)
            0: if (e) begin n.st = 1; n.run = 0; end
            1: if (tmo) n.st = 0;
               else if (e) begin
                   n.run = ok ? m.run + 1 : 0;
                   if (n.run == LOCK_CNT) begin n.st = 2; n.run = 0; end
               end
            default: if (tmo || (e && !ok)) begin n.st = 0; drop = 1'b1; end
        endcase
        n.locked = (m.st == 2);
        n.lost = drop ? 1'b1 : (clr ? 1'b0 : m.lost);
        n.res = creset; n.resq = m.res; n.inh = cinh;
        if (align ? fire : m.res) n.cnt = 0;
        else if (!m.inh) n.cnt = (m.cnt + 1) & ((longint'(1) << cw) - 1);
        if (fire) n.pend = 1'b0;
        else if (align && m.res && !m.resq) n.pend = 1'b1;
        return n;
    endfunction

    function automatic exp_t xp(mdl_t m);
        exp_t e;
        e.cnt = m.cnt[31:0]; e.locked = m.locked; e.lost = m.lost;
        e.period = m.period[7:0]; e.pend = m.pend;
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_vec(input string tag, input exp_t o, input exp_t e);
        vectors++;
        assert (o === e) else begin
            miscompares++;
            $error("FAIL %s cycle %0d observed cnt=%0h lk=%0b lost=%0b per=%0d pend=%0b expected cnt=%0h lk=%0b lost=%0b per=%0d pend=%0b",
                   tag, cyc, o.cnt, o.locked, o.lost, o.period, o.pend, e.cnt, e.locked, e.lost, e.period, e.pend);
        end
    endtask

    // Scoreboard producer: expected outputs for the inputs just sampled
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ma <= '0;
            mb <= '0;
            qa.delete();
            qb.delete();
        end else begin
            cyc <= cyc + 1;
            qa.push_back(xp(mstep(ma, freqin, cnt_reset, cnt_inhibit, clear_lost, 1'b0, 22)));
            qb.push_back(xp(mstep(mb, freqin, cnt_reset, cnt_inhibit, clear_lost, 1'b1, 8)));
            ma <= mstep(ma, freqin, cnt_reset, cnt_inhibit, clear_lost, 1'b0, 22);
            mb <= mstep(mb, freqin, cnt_reset, cnt_inhibit, clear_lost, 1'b1, 8);
        end
    end

    always @(negedge clk) begin
        if (reset_n && qa.size() > 0)
            check_vec("model_a", '{cnt: 32'(counter_a), locked: locked_a, lost: lost_a,
                      period: 8'(period_a), pend: align_pending_a}, qa.pop_front());
        if (reset_n && qb.size() > 0)
            check_vec("model_b", '{cnt: 32'(counter_b), locked: locked_b, lost: lost_b,
                      period: 8'(period_b), pend: align_pending_b}, qb.pop_front());
    end

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic ref_period(input int len);
        for (int i = 0; i < len; i++) begin
            freqin = (i < len / 2);
            tick(1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach its end");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] wexp [4];
        logic [7:0] c0;
        int w;
        wexp = '{8'hFE, 8'hFF, 8'h00, 8'h01};
        c0 = '0;
        #1 reset_n = 1'b0;
        tick(3);
        check("rst_cnt_a", 32'(counter_a), 0);
        check("rst_flags_a", {locked_a, lost_a, align_pending_a}, 0);
        check("rst_period_a", 32'(period_a), 0);
        check("rst_b", {counter_b, locked_b, lost_b, period_b, align_pending_b}, 0);
        reset_n = 1'b1;

        // Counter wrap on the narrow instance
        w = 0;
        while (counter_b !== 8'hFE && w < 400) begin tick(1); w++; end
        check("wrap_reached", 32'(w < 400), 1);
        for (int i = 0; i < 4; i++) begin
            check("wrap_seq", 32'(counter_b), 32'(wexp[i]));
            tick(1);
        end

        // Acquire lock on a steady reference
        repeat (4) ref_period(8);
        check("t1_not_yet_locked", 32'(locked_a), 0);
        repeat (2) ref_period(8);
        check("t1_locked", 32'(locked_a), 1);
        check("t1_period", 32'(period_a), 8);
        check("t1_lost", 32'(lost_a), 0);

        // Reference stuck high
        freqin = 1'b1;
        tick(20);
        check("t2_locked_before_drop", 32'(locked_a), 1);
        check("t2_lost_set", 32'(lost_a), 1);
        tick(1);
        check("t2_locked_drop", 32'(locked_a), 0);
        tick(10);
        check("t2_period_kept", 32'(period_a), 8);
        clear_lost = 1'b1;
        tick(1);
        clear_lost = 1'b0;
        check("t2_clear_lost", 32'(lost_a), 0);

        // Relock, then one long period
        freqin = 1'b0;
        tick(4);
        repeat (6) ref_period(8);
        check("t3_relocked", 32'(locked_a), 1);
        ref_period(10);
        ref_period(8);
        check("t3_period10", 32'(period_a), 10);
        check("t3_unlocked", 32'(locked_a), 0);
        check("t3_lost", 32'(lost_a), 1);
        repeat (6) ref_period(8);
        check("t3_relock_again", 32'(locked_a), 1);
        check("t3_period8", 32'(period_a), 8);

        // Edge-aligned reset on the ALIGN instance
        for (int i = 0; i < 8; i++) begin
            freqin = (i < 4);
            cnt_reset = (i == 3) || (i == 5);
            if (i == 6) c0 = counter_b;
            tick(1);
        end
        cnt_reset = 1'b0;
        check("t5_pending", 32'(align_pending_b), 1);
        check("t5_still_counting", 32'(counter_b), 32'(8'(c0 + 8'd2)));
        ref_period(8);
        check("t5_pending_clear", 32'(align_pending_b), 0);
        check("t5_counter_aligned", 32'(counter_b), 5);

        // Reset and inhibit together on the default instance
        cnt_reset = 1'b1;
        cnt_inhibit = 1'b1;
        tick(2);
        check("t4_cleared", 32'(counter_a), 0);
        tick(5);
        check("t4_held", 32'(counter_a), 0);
        cnt_reset = 1'b0;
        tick(3);
        check("t4_inhibit_holds", 32'(counter_a), 0);
        cnt_inhibit = 1'b0;
        tick(1);
        check("t4_release_lag", 32'(counter_a), 0);
        tick(1);
        check("t4_resume", 32'(counter_a), 1);

        // Asynchronous reset while acquiring
        repeat (2) ref_period(8);
        @(posedge clk);
        #2;
        check("t6_cnt_nonzero", 32'(counter_a != 22'd0), 1);
        reset_n = 1'b0;
        #1;
        check("t6_cnt_a", 32'(counter_a), 0);
        check("t6_flags_a", {locked_a, lost_a, align_pending_a}, 0);
        check("t6_period_a", 32'(period_a), 0);
        check("t6_b", {counter_b, locked_b, lost_b, period_b, align_pending_b}, 0);
        tick(2);
        reset_n = 1'b1;
        tick(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
